// File: rtl/inst_fetch_if.sv
// Bundle between the fetch stage and its neighbours: ROM lookup, execute
// control (redirect/halt), the decode handshake and status.
interface inst_fetch_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [7:0]  out_pc;
  logic        halted;
  logic [15:0] fetch_cnt;

  modport master (
    output rom_addr, out_valid, out_inst, out_pc, halted, fetch_cnt,
    input  rom_data, redirect_valid, redirect_addr, halt_req, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_inst, out_pc, halted, fetch_cnt,
    output rom_data, redirect_valid, redirect_addr, halt_req, out_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads the ROM combinationally and buffers
// {pc, inst} pairs in a circular prefetch queue drained by decode.
//   state | meaning
//   RUN   | fetching enabled, one push per cycle when the queue has room
//   HALT  | no pushes, PC held; queue still drains; left only by redirect
module inst_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         DEPTH    = 2
) (
  input logic         CLK,
  input logic         RST,
  inst_fetch_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t        state;
  logic          halted_q;
  logic [7:0]    pc;
  logic [15:0]   q_inst [DEPTH];
  logic [7:0]    q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   fcnt;
  logic          valid, pop, push;

  assign valid = (count != '0);
  assign pop   = valid & bus.out_ready;
  // A full queue can still accept when the head leaves in the same cycle.
  assign push  = (state == RUN) & ~bus.redirect_valid & ~bus.halt_req &
                 ((count < FULL) | pop);

  assign bus.rom_addr  = pc;
  assign bus.out_valid = valid;
  assign bus.out_inst  = valid ? q_inst[rd_ptr] : 16'h0000;
  assign bus.out_pc    = valid ? q_pc[rd_ptr]   : 8'h00;
  assign bus.halted    = halted_q;
  assign bus.fetch_cnt = fcnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= RUN;
      halted_q <= 1'b0;
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fcnt     <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= 16'h0000;
        q_pc[i]   <= 8'h00;
      end
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything: flush, retarget, resume.
      state    <= RUN;
      halted_q <= 1'b0;
      pc       <= bus.redirect_addr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        RUN: if (bus.halt_req) begin
          state    <= HALT;
          halted_q <= 1'b1;
        end
        default: ;
      endcase

      if (push) begin
        q_inst[wr_ptr] <= bus.rom_data;
        q_pc[wr_ptr]   <= pc;
        wr_ptr         <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        pc             <= pc + 8'd1;
        if (fcnt != 16'hFFFF) fcnt <= fcnt + 16'd1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule
